// File: rtl/cirno9_sram_resp_pkg.sv
// Shared definitions for the LSU SRAM responder: state encoding, default
// array depth, wait-counter width, latched request layout, window check.
// Pure declarations, no logic.
package cirno9_sram_resp_pkg;

    // Default word-address width (2**12 words = 16 KiB).
    localparam int CIRNO_RAM_AW     = 12;
    // Width of the wait-state counter; WAIT_CYC must fit in it (0..15).
    localparam int CIRNO_RAM_WAIT_W = 4;

    typedef enum logic [1:0] {
        CIRNO_RAM_ST_IDLE = 2'd0,
        CIRNO_RAM_ST_WAIT = 2'd1,
        CIRNO_RAM_ST_ACC  = 2'd2,
        CIRNO_RAM_ST_RESP = 2'd3
    } ram_st_t;

    // Request fields captured at acceptance; the inputs are don't-care after.
    typedef struct packed {
        logic        ren;
        logic [3:0]  wen;
        logic [31:0] wdat;
        logic        err;
    } ram_req_t;

    // off is the byte offset from the window base. Anything at or beyond
    // 4*2**aw bytes (including addresses below base, which wrap to large
    // values) lies outside the window.
    function automatic logic ram_out_of_window(input logic [31:0] off, input int aw);
        return (off >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/cirno9_sram_array.sv
// Single-port word array with 4 byte-write lanes and a synchronous read port.
// Latency: read data appears the cycle after an enabled read (we == 0).
// Backpressure: none; one access per enabled cycle. Contents are never reset.
//   clk  : clock            en   : access enable
//   we   : byte lane enables (0 = read)
//   idx  : word index       wdat : write data     rdat : registered read data
module cirno9_sram_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdat,
    output logic [31:0]   rdat
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (we[lane]) begin
                    mem[idx][8*lane +: 8] <= wdat[8*lane +: 8];
                end
            end
            // A write leaves the read register alone so the last read word
            // stays available.
            if (we == 4'h0) begin
                rdat <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/cirno9_sram_resp.sv
// LSU SRAM responder: val/rdy word read / byte-masked write into a local array.
// Latency: acceptance edge to end of the ack cycle is WAIT_CYC+2 cycles.
// Backpressure: rdy drops for WAIT_CYC+1 cycles after each accept; the ack cycle accepts again.
//   hs_ls4ram_val / hs_ram4ls_rdy : request handshake
//   i_ren, i_wen, i_adr, i_wdat   : request fields, sampled only on val&rdy
//   o_ack, o_err, o_rdat          : one-cycle completion, fault flag, read data
module cirno9_sram_resp
    import cirno9_sram_resp_pkg::*;
#(
    parameter int          AW       = CIRNO_RAM_AW,
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int          WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_ls4ram_val,
    output logic        hs_ram4ls_rdy,
    input  logic        i_ren,
    input  logic [3:0]  i_wen,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdat
);

    localparam logic [CIRNO_RAM_WAIT_W-1:0] WAIT_INIT = CIRNO_RAM_WAIT_W'(WAIT_CYC);

    ram_st_t                     state;
    ram_req_t                    lat;
    logic [AW-1:0]               lat_idx;
    logic [CIRNO_RAM_WAIT_W-1:0] cnt;
    logic                        rdy_q;
    logic                        ack_q;
    logic                        err_q;
    logic [31:0]                 rdat_q;

    logic [31:0] off;
    logic        req_err;
    logic        accept;
    logic        arr_en;
    logic [31:0] arr_rdat;
    logic [31:0] rdat_out;

    assign off     = i_adr - BASE;
    assign req_err = ram_out_of_window(off, AW) || (i_ren && (i_wen != 4'h0));
    assign accept  = hs_ls4ram_val && rdy_q;

    // Faulted requests and NOPs never touch the array.
    assign arr_en = (state == CIRNO_RAM_ST_ACC) && !lat.err &&
                    (lat.ren || (lat.wen != 4'h0));

    cirno9_sram_array #(
        .AW (AW)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (lat.wen),
        .idx  (lat_idx),
        .wdat (lat.wdat),
        .rdat (arr_rdat)
    );

    // The array's read register is only valid during RESP; rdat_q keeps the
    // presented value afterwards so o_rdat holds until the next read ack.
    always_comb begin
        rdat_out = rdat_q;
        if (state == CIRNO_RAM_ST_RESP) begin
            if (lat.err) begin
                rdat_out = 32'h0;
            end else if (lat.ren) begin
                rdat_out = arr_rdat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CIRNO_RAM_ST_IDLE;
            lat     <= '0;
            lat_idx <= '0;
            cnt     <= '0;
            rdy_q   <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;

            case (state)
                CIRNO_RAM_ST_WAIT: begin
                    if (cnt == CIRNO_RAM_WAIT_W'(1)) begin
                        state <= CIRNO_RAM_ST_ACC;
                    end
                    cnt <= cnt - 1'b1;
                end
                CIRNO_RAM_ST_ACC: begin
                    state <= CIRNO_RAM_ST_RESP;
                    ack_q <= 1'b1;
                    err_q <= lat.err;
                    rdy_q <= 1'b1;
                end
                CIRNO_RAM_ST_RESP: begin
                    rdat_q <= rdat_out;
                    state  <= CIRNO_RAM_ST_IDLE;
                end
                default: ;
            endcase

            // Acceptance happens in IDLE or RESP (rdy high) and overrides the
            // RESP -> IDLE return above for back-to-back requests.
            if (accept) begin
                lat.ren  <= i_ren;
                lat.wen  <= i_wen;
                lat.wdat <= i_wdat;
                lat.err  <= req_err;
                lat_idx  <= off[AW+1:2];
                cnt      <= WAIT_INIT;
                rdy_q    <= 1'b0;
                state    <= (WAIT_CYC > 0) ? CIRNO_RAM_ST_WAIT : CIRNO_RAM_ST_ACC;
            end
        end
    end

    assign hs_ram4ls_rdy = rdy_q;
    assign o_ack         = ack_q;
    assign o_err         = err_q;
    assign o_rdat        = rdat_out;

endmodule

// File: tb/tb_cirno9_sram_resp.sv
// Scoreboard bench for cirno9_sram_resp: one instance with no wait states,
// one with three. Requests push expected acks; a negedge monitor checks them.
// Cycle budget is bounded on every wait.
module tb_cirno9_sram_resp;

    logic        clk;
    logic        rst_n;
    logic        val  [2];
    logic        ren  [2];
    logic [3:0]  wen  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic        rdy  [2];
    logic        ack  [2];
    logic        err  [2];
    logic [31:0] rdat [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          d;
        logic        err;
        logic [31:0] rdat;
        int          due;
    } exp_t;

    exp_t sb[$];

    cirno9_sram_resp #(.AW(12), .BASE(32'h0), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .hs_ls4ram_val(val[0]), .hs_ram4ls_rdy(rdy[0]),
        .i_ren(ren[0]), .i_wen(wen[0]), .i_adr(adr[0]), .i_wdat(wdat[0]),
        .o_ack(ack[0]), .o_err(err[0]), .o_rdat(rdat[0])
    );

    cirno9_sram_resp #(.AW(12), .BASE(32'h0), .WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .hs_ls4ram_val(val[1]), .hs_ram4ls_rdy(rdy[1]),
        .i_ren(ren[1]), .i_wen(wen[1]), .i_adr(adr[1]), .i_wdat(wdat[1]),
        .o_ack(ack[1]), .o_err(err[1]), .o_rdat(rdat[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation,
    // including the cycle it was due in.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_ack_dut%0d", d), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_dut_id", 32'(d), 32'(e.d));
                    chk("ack_err", {31'd0, err[d]}, {31'd0, e.err});
                    chk("ack_rdat", rdat[d], e.rdat);
                    chk("ack_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (err[d] !== 1'b0) begin
                chk($sformatf("err_without_ack_dut%0d", d), {31'd0, err[d]}, 32'd0);
            end
        end
    end

    // Called at a negedge. Presents the request, waits (bounded) for rdy,
    // records the expected ack, and returns at the following negedge with
    // val still asserted so a further call forms a back-to-back request.
    task automatic issue(input int d, input logic r, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rdat,
                         input bit expect_ack, output int waited);
        exp_t e;
        val[d]  = 1'b1;
        ren[d]  = r;
        wen[d]  = w;
        adr[d]  = a;
        wdat[d] = wd;
        waited  = 0;
        while (rdy[d] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (rdy[d] !== 1'b1) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (expect_ack) begin
            e.d    = d;
            e.err  = e_err;
            e.rdat = e_rdat;
            e.due  = cyc + ((d == 0) ? 0 : 3) + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int d);
        val[d]  = 1'b0;
        ren[d]  = 1'b0;
        wen[d]  = 4'h0;
        adr[d]  = 32'h0;
        wdat[d] = 32'h0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        idle(0);
        idle(1);
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            chk("reset_rdy",  {31'd0, rdy[d]}, 32'd1);
            chk("reset_ack",  {31'd0, ack[d]}, 32'd0);
            chk("reset_err",  {31'd0, err[d]}, 32'd0);
            chk("reset_rdat", rdat[d], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // No wait states: chained requests, each accepted in the previous ack cycle.
        issue(0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1, w);
        chk("w0_first_accept_wait", 32'(w), 32'd0);
        issue(0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1, w);
        chk("w0_b2b_wait", 32'(w), 32'd1);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h11223344, 1'b0, 32'hDEADBEEF, 1, w);
        issue(0, 1'b0, 4'b0100, 32'h20, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF, 1, w);
        issue(0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 32'h11BB3344, 1, w);
        issue(0, 1'b1, 4'h0, 32'h23, 32'h0, 1'b0, 32'h11BB3344, 1, w);
        issue(0, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 32'h11BB3344, 1, w);
        issue(0, 1'b1, 4'h0, 32'h4000, 32'h0, 1'b1, 32'h0, 1, w);
        issue(0, 1'b1, 4'h1, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0, 1, w);
        issue(0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1, w);
        issue(0, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0, 32'hCAFEF00D, 1, w);
        idle(0);
        drain();

        // Three wait states, val held: rdy low 4 cycles per request.
        issue(1, 1'b0, 4'hF, 32'h30, 32'h12345678, 1'b0, 32'h0, 1, w);
        issue(1, 1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 32'h12345678, 1, w);
        chk("w3_rdy_low_cycles_a", 32'(w), 32'd4);
        issue(1, 1'b0, 4'hF, 32'h34, 32'h00000055, 1'b0, 32'h12345678, 1, w);
        chk("w3_rdy_low_cycles_b", 32'(w), 32'd4);
        idle(1);
        drain();

        // Reset while a write to 0x30 is still waiting: it must vanish.
        issue(1, 1'b0, 4'hF, 32'h30, 32'h99999999, 1'b0, 32'h0, 0, w);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_rdy",  {31'd0, rdy[1]}, 32'd1);
        chk("post_reset_rdat", rdat[1], 32'd0);
        issue(1, 1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 32'h12345678, 1, w);
        issue(1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b0, 32'h12345678, 1, w);
        idle(1);
        drain();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
